// File: rtl/dot_accumulator_pkg.sv
// ============================================================================
// Module : dot_accumulator_pkg
// Brief  : State encodings, default sizing and the 4-bit CLA cell for the
//          dot-product accumulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dot_accumulator_pkg;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    localparam int c_def_len   = 4;
    localparam int c_def_acc_w = 12;

    // 4-bit carry-lookahead cell: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dot_accumulator_acc_add.sv
// ============================================================================
// Module : acc_add
// Brief  : ACC_W-bit accumulator adder (acc + 8-bit product) with carry out,
//          built from chained 4-bit CLA cells on zero-padded operands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module acc_add
    import dot_accumulator_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [7:0]       i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_cout
);

    localparam int c_nb = (ACC_W + 3) / 4;
    localparam int c_pw = c_nb * 4;

    logic [c_pw-1:0] w_a;
    logic [c_pw-1:0] w_b;
    logic [c_pw-1:0] w_s;
    logic [c_nb:0]   w_c;
    logic [c_pw:0]   w_full;

    assign w_a    = c_pw'(i_a);
    assign w_b    = c_pw'(i_b);
    assign w_c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < c_nb; gi++) begin : g_cla
            logic [4:0] w_r;
            assign w_r             = cla4(w_a[4*gi +: 4], w_b[4*gi +: 4], w_c[gi]);
            assign w_s[4*gi +: 4]  = w_r[3:0];
            assign w_c[gi+1]       = w_r[4];
        end
    endgenerate

    // Operands are zero above ACC_W, so bit ACC_W of the padded sum is the true carry
    assign w_full = {w_c[c_nb], w_s};
    assign o_sum  = w_full[ACC_W-1:0];
    assign o_cout = w_full[ACC_W];

endmodule

`default_nettype wire

// File: rtl/dot_accumulator.sv
// ============================================================================
// Module : dot_accumulator
// Brief  : Accumulates LEN 8-bit products per frame and presents the sum on a
//          valid/ready output; frames may be closed early with flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dot_accumulator
    import dot_accumulator_pkg::*;
#(
    parameter int LEN   = c_def_len,
    parameter int ACC_W = c_def_acc_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_prod,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_sum,
    output logic [$clog2(LEN):0]  out_cnt,
    output logic                  out_ovf
);

    localparam int             c_cw       = $clog2(LEN);
    localparam logic [c_cw-1:0] c_last_cnt = c_cw'(LEN - 1);

    logic [1:0]       r_state,     w_state_nxt;
    logic [ACC_W-1:0] r_acc,       w_acc_nxt;
    logic [c_cw-1:0]  r_cnt,       w_cnt_nxt;
    logic             r_ovf,       w_ovf_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [ACC_W-1:0] r_out_sum,   w_out_sum_nxt;
    logic [c_cw:0]    r_out_cnt,   w_out_cnt_nxt;
    logic             r_out_ovf,   w_out_ovf_nxt;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_fresh;
    logic             w_last;
    logic [ACC_W-1:0] w_base_acc;
    logic [c_cw-1:0]  w_base_cnt;
    logic             w_base_ovf;
    logic [ACC_W-1:0] w_sum;
    logic             w_cout;

    assign w_in_ready = !r_out_valid | out_ready;
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Outside ACCUM any accepted product opens a new frame, so start from zero
    assign w_fresh    = (r_state != c_st_accum);
    assign w_base_acc = w_fresh ? '0 : r_acc;
    assign w_base_cnt = w_fresh ? '0 : r_cnt;
    assign w_base_ovf = w_fresh ? 1'b0 : r_ovf;
    assign w_last     = w_in_fire & ((w_base_cnt == c_last_cnt) | flush);

    acc_add #(.ACC_W(ACC_W)) u_acc_add (
        .i_a    (w_base_acc),
        .i_b    (in_prod),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = r_out_valid;
        w_out_sum_nxt   = r_out_sum;
        w_out_cnt_nxt   = r_out_cnt;
        w_out_ovf_nxt   = r_out_ovf;

        if (w_out_fire) begin
            w_state_nxt     = c_st_idle;
            w_out_valid_nxt = 1'b0;
        end

        if (w_in_fire) begin
            if (w_last) begin
                w_state_nxt     = c_st_hold;
                w_out_valid_nxt = 1'b1;
                w_out_sum_nxt   = w_sum;
                w_out_cnt_nxt   = {1'b0, w_base_cnt} + 1'b1;
                w_out_ovf_nxt   = w_base_ovf | w_cout;
                w_acc_nxt       = '0;
                w_cnt_nxt       = '0;
                w_ovf_nxt       = 1'b0;
            end else begin
                w_state_nxt = c_st_accum;
                w_acc_nxt   = w_sum;
                w_cnt_nxt   = w_base_cnt + 1'b1;
                w_ovf_nxt   = w_base_ovf | w_cout;
            end
        end else if (flush && (r_state == c_st_accum)) begin
            w_state_nxt     = c_st_hold;
            w_out_valid_nxt = 1'b1;
            w_out_sum_nxt   = r_acc;
            w_out_cnt_nxt   = {1'b0, r_cnt};
            w_out_ovf_nxt   = r_ovf;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_ovf_nxt       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_sum   <= w_out_sum_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_out_ovf   <= w_out_ovf_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;

endmodule

`default_nettype wire
